pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline control unit for the six-stage core: PC, IF, ID, EX, LS and WB.
- Merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register, including the EX/LS register.
- Sequences branch redirects and traps. A trap first drains an in-flight LS access, then issues a one-cycle flush and redirect.
- Runs a stall watchdog.

Parameters:
- PC_WIDTH, 32, width of redirect addresses.
- WDT_CYCLES, 1024, number of consecutive IDLE stall cycles before stall_timeout_o pulses; minimum 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stallreq_if_i  in  1  IF stage stall request
- stallreq_id_i  in  1  ID stage stall request
- stallreq_ex_i  in  1  EX stage stall request, e.g. multicycle divide
- stallreq_ls_i  in  1  LS stage stall request, memory access pending
- jump_req_i  in  1  taken branch or jump resolved in EX
- jump_addr_i  in  PC_WIDTH  branch or jump target
- trap_req_i  in  1  trap request; level signal held until trap_ack_o
- trap_addr_i  in  PC_WIDTH  trap vector
- stall_o  out  6  stall vector; bit0=PC, 1=IF, 2=ID, 3=EX, 4=LS, 5=WB
- flush_o  out  6  flush vector, same bit mapping
- redirect_o  out  1  PC redirect strobe
- redirect_pc_o  out  PC_WIDTH  redirect target
- trap_ack_o  out  1  one-cycle trap acknowledge
- stall_timeout_o  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, trap_pc_q=0, wdt_cnt=0.
  - All outputs 0 while rst_n is low, regardless of inputs.
- Base stall vector (combinational; the highest requesting stage wins):
  - ls → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
  - stall_o[5] is always 0.
- FSM states: IDLE, DRAIN, FLUSH, HOLD.
- IDLE:
  - stall_o = base vector.
  - If trap_req_i: latch trap_pc_q <= trap_addr_i, go to DRAIN. In that cycle the jump is ignored and no flush or redirect is issued.
  - Else if jump_req_i && !stall_o[3]: same cycle, flush_o = 6'b000110 (IF/ID and ID/EX), redirect_o = 1, redirect_pc_o = jump_addr_i.
  - A jump while stall_o[3]=1 is not taken that cycle; EX holds it and re-presents it.
- DRAIN:
  - stall_o = base vector | 6'b001111 (front end and EX frozen; LS runs).
  - jump_req_i ignored.
  - When stallreq_ls_i = 0, go to FLUSH. The transition is evaluated every cycle, so DRAIN lasts a minimum of 1 cycle.
- FLUSH (exactly 1 cycle):
  - flush_o = 6'b011111, stall_o = 0, redirect_o = 1, redirect_pc_o = trap_pc_q, trap_ack_o = 1.
  - Next state HOLD.
- HOLD (1 cycle):
  - Outputs as IDLE except trap_req_i and jump_req_i are ignored (the requester drops the trap after the ack).
  - Next state IDLE.
- Whenever redirect_o = 0, redirect_pc_o = 0.
- trap_pc_q changes only on IDLE→DRAIN. A trap_addr_i change after acceptance has no effect.
- Watchdog:
  - In IDLE with stall_o[0] = 1, wdt_cnt increments; otherwise wdt_cnt clears to 0.
  - When wdt_cnt == WDT_CYCLES-1 and it would increment, stall_timeout_o = 1 for that cycle and wdt_cnt wraps to 0.
  - The watchdog is informational only; it does not alter the stall vector.
- Reset mid-trap: state returns to IDLE, no trap_ack_o is issued; the requester re-raises the trap after reset.
- Counter width: clog2(WDT_CYCLES).
- Flush takes precedence over stall at the pipeline registers. FLUSH drives stall_o = 0, so no conflicting combinations are produced.

Test Plan:
1. After reset release with all inputs 0: stall_o = 0, flush_o = 0. Assert stallreq_ex_i → stall_o = 6'b001111 in the same cycle. Add stallreq_ls_i → 6'b011111.
2. jump_req_i = 1, jump_addr_i = 0x80000040, no stalls → same cycle flush_o = 6'b000110, redirect_o = 1, redirect_pc_o = 0x80000040. Repeat with stallreq_ex_i = 1 → flush_o = 0, redirect_o = 0.
3. trap_req_i with trap_addr_i = 0x00000100 and stallreq_ls_i high for 3 more cycles:
   - Stays in DRAIN with stall_o = 6'b011111.
   - One cycle after stallreq_ls_i falls: flush_o = 6'b011111, redirect_pc_o = 0x00000100, trap_ack_o = 1 (single cycle).
   - Then one HOLD cycle, then IDLE.
4. trap_req_i and jump_req_i in the same IDLE cycle → no jump redirect. trap_addr_i changed during DRAIN → FLUSH still redirects to the originally latched address.
5. WDT_CYCLES = 8, stallreq_if_i held 20 cycles → stall_timeout_o pulses on stall cycles 8 and 16. Deasserting the stall for 1 cycle clears the count.
6. rst_n pulsed low during DRAIN → all outputs 0 immediately. After release: state IDLE, trap_ack_o never asserted.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: per-stage stall requests, jump/trap redirects and the resulting control vectors.
// Combinational path only; no storage in the interface.
// No backpressure; trap_req_i is a level held by the requester until trap_ack_o.
interface pipe_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                stallreq_if_i;
    logic                stallreq_id_i;
    logic                stallreq_ex_i;
    logic                stallreq_ls_i;
    logic                jump_req_i;
    logic [PC_WIDTH-1:0] jump_addr_i;
    logic                trap_req_i;
    logic [PC_WIDTH-1:0] trap_addr_i;
    logic [5:0]          stall_o;
    logic [5:0]          flush_o;
    logic                redirect_o;
    logic [PC_WIDTH-1:0] redirect_pc_o;
    logic                trap_ack_o;
    logic                stall_timeout_o;

    // Pipeline side: raises requests, consumes stall/flush/redirect.
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_ls_i,
        output jump_req_i, jump_addr_i, trap_req_i, trap_addr_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, trap_ack_o, stall_timeout_o
    );

    // Controller side.
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_ls_i,
        input  jump_req_i, jump_addr_i, trap_req_i, trap_addr_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o, trap_ack_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Six-stage pipeline control: stall merge, jump redirect, trap drain/flush sequencing, stall watchdog.
// Stall/flush/jump redirect are same-cycle combinational; a trap redirects one cycle after LS drains.
// Stalled jumps are not taken and must be re-presented by EX; traps are held by the requester until ack.
module pipe_ctrl #(
    parameter int PC_WIDTH   = 32,
    parameter int WDT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  ctl
);
    localparam int CW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);
    localparam logic [CW-1:0] WDT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] trap_pc_q, trap_pc_d;
    logic [CW-1:0]       wdt_cnt_q, wdt_cnt_d;

    logic [5:0]          base_stall;
    logic [5:0]          stall;
    logic [5:0]          flush;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                trap_ack;
    logic                stall_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            trap_pc_q <= '0;
            wdt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_pc_q <= trap_pc_d;
            wdt_cnt_q <= wdt_cnt_d;
        end
    end

    // Deepest requesting stage freezes itself and everything upstream.
    always_comb begin
        base_stall = 6'b000000;
        if (ctl.stallreq_ls_i)      base_stall = 6'b011111;
        else if (ctl.stallreq_ex_i) base_stall = 6'b001111;
        else if (ctl.stallreq_id_i) base_stall = 6'b000111;
        else if (ctl.stallreq_if_i) base_stall = 6'b000011;
    end

    always_comb begin
        state_d       = state_q;
        trap_pc_d     = trap_pc_q;
        wdt_cnt_d     = '0;
        stall         = base_stall;
        flush         = 6'b000000;
        redirect      = 1'b0;
        redirect_pc   = '0;
        trap_ack      = 1'b0;
        stall_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctl.trap_req_i) begin
                    trap_pc_d = ctl.trap_addr_i;
                    state_d   = DRAIN;
                end else if (ctl.jump_req_i && !base_stall[3]) begin
                    flush       = 6'b000110;
                    redirect    = 1'b1;
                    redirect_pc = ctl.jump_addr_i;
                end
                if (base_stall[0]) begin
                    if (wdt_cnt_q == WDT_LAST) stall_timeout = 1'b1;
                    else                       wdt_cnt_d     = wdt_cnt_q + WDT_ONE;
                end
            end
            DRAIN: begin
                // Front end and EX hold while the outstanding LS access completes.
                stall = base_stall | 6'b001111;
                if (!ctl.stallreq_ls_i) state_d = FLUSH;
            end
            FLUSH: begin
                stall       = 6'b000000;
                flush       = 6'b011111;
                redirect    = 1'b1;
                redirect_pc = trap_pc_q;
                trap_ack    = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign ctl.stall_o         = rst_n ? stall         : 6'b000000;
    assign ctl.flush_o         = rst_n ? flush         : 6'b000000;
    assign ctl.redirect_o      = rst_n & redirect;
    assign ctl.redirect_pc_o   = rst_n ? redirect_pc   : '0;
    assign ctl.trap_ack_o      = rst_n & trap_ack;
    assign ctl.stall_timeout_o = rst_n & stall_timeout;
endmodule
